// File: rtl/apb_ssd_scan.sv
// apb_ssd_scan: APB3 slave holding up to eight hex digits and scanning them
// onto a shared seven-segment decoder with one-hot digit enables.
// Digit i lives in nibble i of the concatenation {DATA_HI, DATA_LO}.
module apb_ssd_scan #(
  parameter int DIGITS      = 6,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            S_PADDR,
  input  logic                  S_PWRITE,
  input  logic                  S_PSELx,
  input  logic                  S_PENABLE,
  input  logic [15:0]           S_PWDATA,
  output logic [15:0]           S_PRDATA,
  output logic                  S_PREADY,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     digit_en,
  output logic [4*DIGITS-1:0]   digits_flat
);

  localparam int              PW       = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]   PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [2:0]      IDX_LAST = 3'(DIGITS - 1);

  localparam logic [1:0] ADDR_DATA_LO = 2'd0;
  localparam logic [1:0] ADDR_DATA_HI = 2'd1;
  localparam logic [1:0] ADDR_CTRL    = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic                en_q, en_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [2:0]          idx_q, idx_d;
  logic [15:0]         prdata_q, prdata_d;
  logic [DIGITS-1:0]   digitEn_q, digitEn_d;
  logic [3:0]          nibble_q, nibble_d;

  logic                wrCommit;
  logic                setupPhase;
  logic [15:0]         dataLoRd;
  logic [15:0]         dataHiRd;
  logic [15:0]         ctrlRd;
  logic [15:0]         statusRd;

  assign wrCommit   = S_PSELx & S_PENABLE & S_PWRITE;
  assign setupPhase = S_PSELx & ~S_PENABLE;
  assign S_PREADY   = S_PSELx & S_PENABLE;

  // Register-file writes: digits, scan enable and blank mask.
  always_comb begin
    digits_d = digits_q;
    en_d     = en_q;
    blank_d  = blank_q;
    if (wrCommit) begin
      case (S_PADDR)
        ADDR_DATA_LO: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (i < 4) digits_d[4*i +: 4] = S_PWDATA[4*(i%4) +: 4];
          end
        end
        ADDR_DATA_HI: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (i >= 4) digits_d[4*i +: 4] = S_PWDATA[4*(i%4) +: 4];
          end
        end
        ADDR_CTRL: begin
          en_d    = S_PWDATA[0];
          blank_d = S_PWDATA[8 +: DIGITS];
        end
        default: begin
        end
      endcase
    end
  end

  // Scan timing: clear as soon as EN is being dropped, restart from zero on a
  // fresh enable, and only advance when EN was already running.
  always_comb begin
    pre_d = pre_q;
    idx_d = idx_q;
    if (!en_d) begin
      pre_d = '0;
      idx_d = '0;
    end else if (en_q) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end else begin
      pre_d = '0;
      idx_d = '0;
    end
  end

  // Display outputs are computed from next-state so they switch on the same
  // edge as the index, with no intermediate glitch.
  always_comb begin
    digitEn_d = '0;
    nibble_d  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == 3'(i)) begin
        nibble_d     = digits_d[4*i +: 4];
        digitEn_d[i] = en_d & ~blank_d[i];
      end
    end
  end

  // Readback views of each register; unstored digits and reserved bits read 0.
  always_comb begin
    dataLoRd = '0;
    dataHiRd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i < 4) dataLoRd[4*(i%4) +: 4] = digits_q[4*i +: 4];
      else       dataHiRd[4*(i%4) +: 4] = digits_q[4*i +: 4];
    end
    ctrlRd                 = '0;
    ctrlRd[0]              = en_q;
    ctrlRd[8 +: DIGITS]    = blank_q;
    statusRd               = '0;
    statusRd[2:0]          = idx_q;
    statusRd[15]           = en_q;
  end

  // Read data is captured in the setup phase and held until the next setup.
  always_comb begin
    prdata_d = prdata_q;
    if (setupPhase) begin
      case (S_PADDR)
        ADDR_DATA_LO: prdata_d = dataLoRd;
        ADDR_DATA_HI: prdata_d = dataHiRd;
        ADDR_CTRL:    prdata_d = ctrlRd;
        ADDR_STATUS:  prdata_d = statusRd;
        default:      prdata_d = '0;
      endcase
    end
  end

  // All state, with a synchronous reset that also discards any in-flight write.
  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q  <= '0;
      en_q      <= 1'b0;
      blank_q   <= '0;
      pre_q     <= '0;
      idx_q     <= '0;
      prdata_q  <= '0;
      digitEn_q <= '0;
      nibble_q  <= '0;
    end else begin
      digits_q  <= digits_d;
      en_q      <= en_d;
      blank_q   <= blank_d;
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      prdata_q  <= prdata_d;
      digitEn_q <= digitEn_d;
      nibble_q  <= nibble_d;
    end
  end

  assign S_PRDATA    = prdata_q;
  assign digit_en    = digitEn_q;
  assign nibble      = nibble_q;
  assign digits_flat = digits_q;

endmodule

// File: tb/tb_apb_ssd_scan.sv
// tb_apb_ssd_scan: directed and randomized APB traffic against apb_ssd_scan,
// checked every cycle by a cycles-since-enable model of the display scan.
module tb_apb_ssd_scan;

  localparam int DIGITS = 6;
  localparam int RDIV   = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [1:0]          paddr = '0;
  logic                pwrite = 1'b0;
  logic                psel = 1'b0;
  logic                penable = 1'b0;
  logic [15:0]         pwdata = '0;
  logic [15:0]         prdata;
  logic                pready;
  logic [3:0]          nibble;
  logic [DIGITS-1:0]   digitEn;
  logic [4*DIGITS-1:0] digitsFlat;

  int total = 0;
  int bad   = 0;
  bit checkOn = 1'b0;

  logic [3:0]        mDig [DIGITS];
  bit                mEn;
  logic [DIGITS-1:0] mBlank;
  int                mT;
  logic [15:0]       mRd;

  apb_ssd_scan #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(paddr), .S_PWRITE(pwrite), .S_PSELx(psel), .S_PENABLE(penable),
    .S_PWDATA(pwdata), .S_PRDATA(prdata), .S_PREADY(pready),
    .nibble(nibble), .digit_en(digitEn), .digits_flat(digitsFlat)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scan position follows directly from cycles elapsed since the last enable.
  function automatic int mIdx();
    return (mT / RDIV) % DIGITS;
  endfunction

  function automatic logic [15:0] modelRead(input logic [1:0] a);
    case (a)
      2'd0:    return {mDig[3], mDig[2], mDig[1], mDig[0]};
      2'd1:    return {8'h00, mDig[5], mDig[4]};
      2'd2:    return {2'b00, mBlank, 7'd0, mEn};
      default: return {mEn, 12'd0, 3'(mIdx())};
    endcase
  endfunction

  // Reference model: register contents plus an enable-age counter.
  always @(posedge clk) begin : modelUpd
    bit newEn;
    if (reset) begin
      for (int k = 0; k < DIGITS; k++) mDig[k] = 4'h0;
      mEn = 1'b0; mBlank = '0; mT = 0; mRd = '0;
    end else begin
      newEn = mEn;
      if (psel && !penable) mRd = modelRead(paddr);
      if (psel && penable && pwrite) begin
        case (paddr)
          2'd0: for (int k = 0; k < 4; k++) mDig[k] = pwdata[4*k +: 4];
          2'd1: begin mDig[4] = pwdata[3:0]; mDig[5] = pwdata[7:4]; end
          2'd2: begin newEn = pwdata[0]; mBlank = pwdata[13:8]; end
          default: ;
        endcase
      end
      if (!newEn)   mT = 0;
      else if (mEn) mT = mT + 1;
      else          mT = 0;
      mEn = newEn;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin : compare
    logic [DIGITS-1:0]   oh;
    logic [DIGITS-1:0]   expEn;
    logic [4*DIGITS-1:0] expFlat;
    #1;
    if (checkOn) begin
      oh = '0;
      oh[mIdx()] = 1'b1;
      expEn = mEn ? (oh & ~mBlank) : '0;
      for (int k = 0; k < DIGITS; k++) expFlat[4*k +: 4] = mDig[k];
      checkOutput("digit_en", 32'(digitEn), 32'(expEn));
      checkOutput("nibble", 32'(nibble), 32'(mDig[mIdx()]));
      checkOutput("digits_flat", 32'(digitsFlat), 32'(expFlat));
      checkOutput("prdata", 32'(prdata), 32'(mRd));
      checkOutput("pready", 32'(pready), 32'(psel & penable));
    end
  end

  task automatic apbWrite(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apbRead(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk); penable = 1'b1; d = prdata;
    @(negedge clk); psel = 1'b0; penable = 1'b0;
  endtask

  task automatic waitForDigit(input logic [DIGITS-1:0] want, input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      if (digitEn == want) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      total++; bad++;
      $display("[TB] FAIL %s: got timeout expected digit_en %0h", name, want);
    end
  endtask

  // Random APB traffic with occasional resets, checked by the compare process.
  task automatic applyStimulus(input int count);
    logic [15:0] rd;
    logic [15:0] d;
    logic [1:0]  a;
    for (int n = 0; n < count; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
      end else begin
        a = 2'($urandom_range(0, 3));
        d = 16'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          if (a == 2'd2) d[0] = ($urandom_range(0, 3) != 0);
          apbWrite(a, d);
        end else begin
          apbRead(a, rd);
        end
      end
    end
  endtask

  initial begin
    logic [15:0] rd;
    int litCnt;
    int darkHit;

    repeat (2) @(negedge clk);
    checkOn = 1'b1;
    @(negedge clk); reset = 1'b0;

    $display("[TB] reset values");
    checkOutput("rst_digit_en", 32'(digitEn), 32'h0);
    checkOutput("rst_flat", 32'(digitsFlat), 32'h0);
    checkOutput("rst_nibble", 32'(nibble), 32'h0);
    for (int a = 0; a < 4; a++) begin
      apbRead(2'(a), rd);
      checkOutput("rst_read", 32'(rd), 32'h0);
    end

    $display("[TB] digit writes");
    apbWrite(2'd0, 16'h3210);
    apbWrite(2'd1, 16'hAB54);
    apbRead(2'd0, rd);
    checkOutput("read_lo", 32'(rd), 32'h3210);
    apbRead(2'd1, rd);
    checkOutput("read_hi", 32'(rd), 32'h0054);
    checkOutput("flat_543210", 32'(digitsFlat), 32'h543210);

    $display("[TB] scan sequence");
    apbWrite(2'd2, 16'h0001);
    for (int k = 0; k < 24; k++) begin
      checkOutput("scan_en", 32'(digitEn), 32'(1 << (k / 4)));
      checkOutput("scan_nib", 32'(nibble), 32'(k / 4));
      @(negedge clk);
    end
    checkOutput("scan_wrap", 32'(digitEn), 32'h1);

    $display("[TB] blank mask");
    apbWrite(2'd2, 16'h0905);
    litCnt = 0; darkHit = 0;
    for (int k = 0; k < 24; k++) begin
      if (digitEn != 0) litCnt++;
      if (digitEn[0] || digitEn[3]) darkHit++;
      @(negedge clk);
    end
    checkOutput("blank_lit", 32'(litCnt), 32'd16);
    checkOutput("blank_dark", 32'(darkHit), 32'd0);

    $display("[TB] disable mid-slot");
    waitForDigit(6'b000100, "wait_idx2");
    apbWrite(2'd2, 16'h0000);
    checkOutput("dis_digit_en", 32'(digitEn), 32'h0);
    apbRead(2'd3, rd);
    checkOutput("dis_status", 32'(rd), 32'h0000);
    apbWrite(2'd2, 16'h0001);
    for (int k = 0; k < 5; k++) begin
      checkOutput("reen_slot", 32'(digitEn), (k < 4) ? 32'h1 : 32'h2);
      @(negedge clk);
    end

    $display("[TB] reset during access");
    apbWrite(2'd2, 16'h0901);
    waitForDigit(6'b010000, "wait_idx4");
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 2'd0; pwdata = 16'hFFFF;
    @(negedge clk); penable = 1'b1; reset = 1'b1;
    @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0; reset = 1'b0;
    checkOutput("rr_digit_en", 32'(digitEn), 32'h0);
    checkOutput("rr_flat", 32'(digitsFlat), 32'h0);
    checkOutput("rr_nibble", 32'(nibble), 32'h0);
    checkOutput("rr_prdata", 32'(prdata), 32'h0);
    apbRead(2'd0, rd);
    checkOutput("rr_read_lo", 32'(rd), 32'h0);
    apbRead(2'd2, rd);
    checkOutput("rr_read_ctrl", 32'(rd), 32'h0);

    $display("[TB] random traffic");
    apbWrite(2'd2, 16'h0001);
    applyStimulus(300);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
